uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` instance among `NUM_REQ` byte producers (console, debug monitor, status reporter, etc.). It accepts bytes over per-requester valid/ready handshakes and drives the transmitter's `tx_in`/`tx_en`. It holds `tx_en` until the transmitter acknowledges via `tx_busy`, because the transmitter samples `tx_en` only on its baud tick. It then waits for the frame to finish before granting the next byte.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `START_TIMEOUT`, default 65535: max clk cycles to wait for `utx_busy` to rise after `utx_en`; must be ≥ 16 × (CLK_FREQ/BAUD_RATE/16) + 2.
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `req_valid`, input, NUM_REQ: requester i has a byte.
- `req_data`, input, 8×NUM_REQ: byte of requester i at bits [8i+7:8i].
- `req_last`, input, NUM_REQ: byte is last of packet; used only with `UART_ARB_LOCK_EN`.
- `req_ready`, output, NUM_REQ: one-hot accept; transfer occurs on the edge where valid & ready.
- `utx_data`, output, 8: to `uart_tx.tx_in`.
- `utx_en`, output, 1: to `uart_tx.tx_en`.
- `utx_busy`, input, 1: from `uart_tx.tx_busy`.
- `grant_id`, output, clog2(NUM_REQ): index of the requester whose byte is in flight.
- `arb_idle`, output, 1: high in IDLE.
- `timeout_err`, output, 1: one-cycle pulse on start timeout.

## Operation
- **States:**
  - IDLE → START on accept.
  - START → WAIT when `utx_busy`=1.
  - START → IDLE on timeout.
  - WAIT → IDLE when `utx_busy`=0.
- **IDLE:**
  - If `utx_busy`=0 and any `req_valid`, the winner is the first valid index searching from `rr_ptr` upward with wrap-around.
  - `req_ready[winner]`=1 combinationally; all other ready bits are 0.
  - `req_ready` is all-zero outside IDLE or while `utx_busy`=1.
- **On accept edge:**
  - `utx_data` ← `req_data[winner]`.
  - `grant_id` ← winner.
  - `rr_ptr` ← (winner+1) mod NUM_REQ.
  - `utx_en` ← 1, timeout counter ← 0, state → START.
- **START:**
  - `utx_en` is held at 1 and `utx_data` is held stable.
  - On the first edge with `utx_busy`=1: `utx_en` ← 0, state → WAIT.
  - Counter increments each cycle. On reaching `START_TIMEOUT`-1 with busy still low: `utx_en` ← 0, `timeout_err` pulses, state → IDLE. The byte is dropped and `rr_ptr` keeps its advanced value.
- **WAIT:**
  - `utx_data` is held until `utx_busy` falls; then state → IDLE.
  - The next grant can happen in the first IDLE cycle.
- **Requester rules:**
  - `req_data[i]` must be stable while `req_valid[i]`=1 and not accepted.
  - Dropping valid before accept is allowed; the byte is simply not sent.
- **Reset values:**
  - Outputs: `utx_en`=0, `utx_data`=0, `req_ready`=0, `grant_id`=0, `arb_idle`=1, `timeout_err`=0.
  - Internal: `rr_ptr`=0, state IDLE.
- **Reset mid-operation:** abandons the byte immediately. The transmitter shares the reset, so no partial-frame recovery is needed.
- **Widths:**
  - `rr_ptr`/`grant_id` wrap modulo NUM_REQ, with explicit wrap for non-power-of-2 values.
  - The timeout counter is 16 bits and saturates.

## Timing
- Accept edge at cycle T; `utx_en`=1 visible from T+1.
- `utx_busy` rises 1..(baud_tick period) cycles later. `utx_en` deasserts on the edge after busy is seen, so at most one extra baud tick of overlap occurs while busy=1. The transmitter ignores `tx_en` outside IDLE.
- Busy falls at end of stop bit; IDLE on the next edge; the next `req_ready` is combinational in that cycle.
- Minimum inter-byte gap: 2 clk cycles plus the transmitter's IDLE→START wait for a baud tick.
- Simultaneous valid on all requesters: grants rotate strictly (0,1,2,3,0…) starting from `rr_ptr`.

## Configuration
- **`UART_ARB_LOCK_EN` defined:**
  - Accepting a byte with `req_last[winner]`=0 sets `lock`=1 and `lock_id`=winner.
  - While locked, only `lock_id` can win and `rr_ptr` does not advance.
  - Accepting a byte with `req_last`=1 clears the lock and advances `rr_ptr` to `lock_id`+1.
  - A timeout clears the lock.
  - `lock` resets to 0.
- **Undefined:** `req_last` is ignored and every byte is arbitrated independently.

## Test plan
- Reset, then `req_valid`=4'b0001 with data 0x55 → `req_ready[0]` for 1 cycle. `utx_en` stays high until busy rises. The line carries start bit, LSB-first 0x55, and stop bit. `grant_id`=0.
- All four valid with data 0xA0..0xA3 held → bytes transmitted in order A0, A1, A2, A3, then A0 again. `req_ready` is one-hot each time and never asserts while busy.
- `utx_busy` forced low with `START_TIMEOUT`=32 → `timeout_err` pulses at cycle 32 after `utx_en`, `utx_en` drops, `arb_idle`=1, and the next requester is served.
- Assert reset during WAIT of byte 0x3C → all outputs return to reset values the same cycle. After release, a new request is granted from requester 0.
- With `UART_ARB_LOCK_EN`: requester 1 sends 3 bytes (last on the 3rd) while requester 2 is continuously valid → output order is R1, R1, R1, R2. Without the macro the order is R1, R2, R1, R2….
- `req_valid[3]` dropped before accept while busy → no byte from 3 is sent and no `req_ready[3]` pulse occurs.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one uart_tx: per-requester valid/ready in, tx_in/tx_en out.
// Optional packet locking (req_last) is compiled in when UART_ARB_LOCK_EN is defined.
//
// state | meaning
// IDLE  | free; combinational grant to first valid requester from rr_ptr
// START | utx_en held until the transmitter raises busy, or start timeout
// WAIT  | frame on the line; hold utx_data until busy falls
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 utx_data,
  output logic                       utx_en,
  input  logic                       utx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       arb_idle,
  output logic                       timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [15:0] TMO_LAST = 16'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_nxt, winner;
  logic [7:0]      win_data;
  logic [15:0]     tmo_cnt;
  logic [NUM_REQ-1:0] eligible;
  logic            found, accept, tmo_hit;

`ifdef UART_ARB_LOCK_EN
  logic          lock;
  logic [IW-1:0] lock_id;

  // A locked packet owner is the only candidate until its last byte is taken.
  always_comb begin
    eligible = req_valid;
    if (lock) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (IW'(i) != lock_id) eligible[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (accept) begin
      lock    <= ~req_last[winner];
      lock_id <= winner;
    end else if (tmo_hit) begin
      lock    <= 1'b0;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  always_comb eligible = req_valid;
`endif

  // Search upward from rr_ptr with explicit wrap (NUM_REQ need not be a power of 2).
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && eligible[idx]) begin
        found    = 1'b1;
        winner   = idx[IW-1:0];
        win_data = req_data[8*idx +: 8];
      end
    end
  end

  assign rr_nxt   = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign accept   = (state == S_IDLE) && !utx_busy && found;
  assign arb_idle = (state == S_IDLE);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (winner == IW'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: begin
        if (utx_busy) begin
          state_nxt = S_WAIT;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = S_IDLE;
          tmo_hit   = 1'b1;
        end
      end
      S_WAIT:  if (!utx_busy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      utx_en      <= 1'b0;
      utx_data    <= '0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_err <= tmo_hit;
      if (accept) begin
        utx_data <= win_data;
        grant_id <= winner;
        rr_ptr   <= rr_nxt;
        utx_en   <= 1'b1;
        tmo_cnt  <= '0;
      end else if (state == S_START) begin
        if (utx_busy || tmo_hit) utx_en <= 1'b0;
        if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end

endmodule
